// File: rtl/mux_lut_prog.sv
// rtl/mux_lut_prog.sv - programmable 2^N_IN:1 mux LUT cell with serial table load
//
// Purpose: reconfigurable gate. The registered output y is the active truth-table
// bit selected by sel. The truth table is loaded serially, MSB first, through a
// valid/ready port. A completed load becomes active in a single commit cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   evaluation request this cycle
//   sel        table index (mux select), N_IN bits
//   out_valid  y holds a fresh result
//   y          registered lut[sel]
//   cfg_valid  cfg_bit is offered
//   cfg_ready  cfg_bit can be accepted (low in COMMIT and while rst is high)
//   cfg_bit    serial truth-table bit, MSB first
//   cfg_abort  discard a partial load (ignored during COMMIT)
//   cfg_done   one-cycle pulse while the new table is being committed
module mux_lut_prog #(
  parameter int N_IN = 2,
  parameter logic [(2**N_IN)-1:0] RESET_TABLE = {((2**N_IN)/2){2'b01}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] sel,
  output logic            out_valid,
  output logic            y,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_done
);

  localparam int TBL = 2**N_IN;
  localparam int IW  = N_IN;      // index width into the table
  localparam int CW  = IW + 1;    // count width; holds TBL without wrapping

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          state;
  logic [TBL-1:0]  lut_q;
  logic [TBL-1:0]  shadow;
  logic [CW-1:0]   count;
  logic [IW-1:0]   wr_idx;
  logic            xfer;

  // cfg_ready is decoded from state; rst gates it so it reads low during reset.
  assign cfg_ready = !rst && (state != S_COMMIT);
  assign xfer      = cfg_valid && cfg_ready;

  // MSB-first: the c-th accepted bit lands at TBL-1-c.
  assign wr_idx = {IW{1'b1}} - count[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lut_q     <= RESET_TABLE;
      shadow    <= '0;
      count     <= '0;
      y         <= 1'b0;
      out_valid <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      // Evaluation is independent of configuration; the commit edge still
      // reads the old lut_q because the update below is non-blocking.
      out_valid <= in_valid;
      if (in_valid) begin
        y <= lut_q[sel];
      end

      cfg_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_abort) begin
            count <= '0;
          end else if (xfer) begin
            shadow[TBL-1] <= cfg_bit;
            count         <= CW'(1);
            state         <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (cfg_abort) begin
            count <= '0;
            state <= S_IDLE;
          end else if (xfer) begin
            shadow[wr_idx] <= cfg_bit;
            count          <= count + CW'(1);
            if (count == CW'(TBL - 1)) begin
              state    <= S_COMMIT;
              cfg_done <= 1'b1;
            end
          end
        end

        S_COMMIT: begin
          lut_q <= shadow;
          count <= '0;
          state <= S_IDLE;
        end

        default: begin
          count <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_lut_prog.sv
// tb/tb_mux_lut_prog.sv - self-checking bench for mux_lut_prog with a behavioural reference model
module tb_mux_lut_prog;

  localparam int N_IN = 2;
  localparam int TBL  = 1 << N_IN;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [N_IN-1:0] sel;
  logic            out_valid;
  logic            y;
  logic            cfg_valid;
  logic            cfg_ready;
  logic            cfg_bit;
  logic            cfg_abort;
  logic            cfg_done;

  mux_lut_prog #(.N_IN(N_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sel       (sel),
    .out_valid (out_valid),
    .y         (y),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .cfg_done  (cfg_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: active table, list of bits received so far, commit flag.
  logic [TBL-1:0] m_tbl;
  bit             m_q[$];
  bit             m_commit;
  logic           m_y;
  bit             last_cb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tbl    = 4'b0101;
    m_q.delete();
    m_commit = 1'b0;
    m_y      = 1'b0;
  endtask

  // One clock: drive at negedge, check ready before the edge, outputs after it.
  task automatic step(input bit iv, input logic [N_IN-1:0] s, input bit cv, input bit cb, input bit ca);
    bit exp_done;
    @(negedge clk);
    in_valid  = iv;
    sel       = s;
    cfg_valid = cv;
    cfg_bit   = cb;
    cfg_abort = ca;
    last_cb   = cb;
    #1;
    check("cfg_ready", cfg_ready, !m_commit);
    if (iv) m_y = m_tbl[s];
    exp_done = 1'b0;
    if (m_commit) begin
      for (int c = 0; c < TBL; c++) m_tbl[TBL-1-c] = m_q[c];
      m_q.delete();
      m_commit = 1'b0;
    end else if (ca) begin
      m_q.delete();
    end else if (cv) begin
      m_q.push_back(cb);
      if (m_q.size() == TBL) begin
        m_commit = 1'b1;
        exp_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("y", y, m_y);
    check("out_valid", out_valid, iv);
    check("cfg_done", cfg_done, exp_done);
  endtask

  task automatic load(input logic [TBL-1:0] v);
    for (int c = 0; c < TBL; c++) step(1'b0, '0, 1'b1, v[TBL-1-c], 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);   // commit cycle
  endtask

  task automatic sweep(input logic [TBL-1:0] exp_tbl);
    for (int s = 0; s < TBL; s++) begin
      step(1'b1, N_IN'(s), 1'b0, 1'b0, 1'b0);
      check("table", y, exp_tbl[s]);
    end
  endtask

  initial begin
    bit gv[7];
    int done_cnt;
    logic [TBL-1:0] gbits;
    int gk;
    rst = 1'b1; in_valid = 0; sel = '0; cfg_valid = 0; cfg_bit = 0; cfg_abort = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", y, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_cfg_done", cfg_done, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: default inverter, then idle hold
    sweep(4'b0101);
    step(1'b0, 2'd1, 0, 0, 0);
    check("hold_y", y, 1'b0);

    // 2: AND table, cfg_done counted
    done_cnt = 0;
    for (int c = 0; c < TBL + 1; c++) begin
      step(1'b0, '0, 1'b1, (c == 0), 1'b0);
      if (cfg_done) done_cnt++;
    end
    step(0, '0, 0, 0, 0);
    if (cfg_done) done_cnt++;
    check("and_done_pulses", done_cnt, 1);
    sweep(4'b1000);

    // 3: evaluate sel=1 every cycle while loading 4'b0010 over 4'b0101
    load(4'b0101);
    for (int c = 0; c < TBL; c++) step(1'b1, 2'd1, 1'b1, c == 2, 1'b0);
    step(1'b1, 2'd1, 0, 0, 0);
    check("commit_edge_old", y, 1'b0);
    step(1'b1, 2'd1, 0, 0, 0);
    check("after_commit_new", y, 1'b1);

    // 4: gapped cfg_valid 1,0,0,1,1,0,1 carrying 4'b1001
    gv = '{1, 0, 0, 1, 1, 0, 1};
    gbits = 4'b1001;
    gk = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, '0, gv[i], gv[i] ? gbits[TBL-1-gk] : 1'b0, 0);
      if (gv[i]) gk++;
    end
    step(0, '0, 0, 0, 0);
    sweep(4'b1001);

    // 5: abort mid-load, then XOR
    load(4'b0101);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 1);
    step(0, '0, 0, 0, 0);
    sweep(4'b0101);
    load(4'b0110);
    sweep(4'b0110);

    // 6: async reset mid-load
    load(4'b1000);
    step(1, 2'd3, 1, 1, 0);
    step(1, 2'd3, 1, 1, 0);
    step(1, 2'd3, 1, 1, 0);
    @(negedge clk);
    in_valid = 0; cfg_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("async_y", y, 0);
    check("async_out_valid", out_valid, 0);
    check("async_cfg_ready", cfg_ready, 0);
    check("async_cfg_done", cfg_done, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    sweep(4'b0101);
    load(4'b1000);
    sweep(4'b1000);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit cb;
      cb = m_commit ? last_cb : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), N_IN'($urandom_range(0, TBL - 1)),
           1'($urandom_range(0, 1)), cb, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_lut_prog.md
Name: mux_lut_prog

Overview:
- Programmable look-up-table cell built from a 2^N_IN:1 mux tree whose data inputs are a runtime-loaded truth table, not hardwired constants.
- Generalises the mux-with-constants gate idea. After reset it behaves as an inverter on sel[0]; any N_IN-input boolean function can then be loaded serially.
- Sits in the combinational-logic exercise fabric as a reconfigurable gate with a registered output and a valid/ready configuration port.

Parameters:
- N_IN, 2, number of select inputs; table depth TBL = 2**N_IN. Legal range 1..6.
- RESET_TABLE, {TBL/2{2'b01}}, TBL-bit table loaded on reset. Bit k = ~k[0], so y = ~sel[0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  evaluation request this cycle.
- sel  input  N_IN  table index (mux select).
- out_valid  output  1  y holds a fresh result.
- y  output  1  registered table[sel].
- cfg_valid  input  1  cfg_bit is offered.
- cfg_ready  output  1  cfg_bit can be accepted.
- cfg_bit  input  1  serial truth-table bit.
- cfg_abort  input  1  discard a partial load.
- cfg_done  output  1  one-cycle pulse when the new table becomes active.

Behaviour:
- Reset (async, rst=1):
  - active table = RESET_TABLE; shadow = 0; count = 0; state = IDLE.
  - y=0, out_valid=0, cfg_done=0, cfg_ready=0 while rst is high.
  - A mid-load reset discards the partial load; the table returns to RESET_TABLE.
- Evaluation path, fixed latency 1:
  - Edge with in_valid=1: y <= table[sel] (active table), out_valid <= 1.
  - Edge with in_valid=0: out_valid <= 0; y holds its previous value.
  - Evaluation is never stalled by configuration. It always uses the table active at that edge.
- Configuration handshake:
  - A bit transfers on an edge with cfg_valid && cfg_ready.
  - cfg_bit must be stable while cfg_valid=1 && cfg_ready=0.
  - Bits are sent MSB first: the c-th accepted bit (c=0..TBL-1) is written to shadow[TBL-1-c].
- FSM states:
  - IDLE: cfg_ready=1, count=0. A transfer stores the bit, sets count=1 and moves to LOAD. If TBL==1 were allowed it would go straight to COMMIT; it is excluded by N_IN>=1.
  - LOAD: cfg_ready=1. Each transfer stores a bit and increments count. The transfer with count==TBL-1 moves to COMMIT. cfg_valid=0 simply waits; there is no timeout.
  - COMMIT (1 cycle): cfg_ready=0; table <= shadow; cfg_done=1 for this cycle; next state IDLE, count <= 0.
- cfg_abort:
  - In IDLE or LOAD: state <= IDLE, count <= 0, shadow unchanged but unused. Any transfer in the same cycle is ignored; abort wins.
  - In COMMIT: ignored; the commit completes.
- Simultaneous events:
  - An evaluation in the COMMIT cycle edge sees the OLD table.
  - The first evaluation edge after the COMMIT edge sees the new table.
- Width rules: count is $clog2(TBL)+1 bits so no wrap occurs. sel is used unmodified as the index.

Test Plan:
1. Reset default NOT, N_IN=2: after rst, drive in_valid=1 with sel=0,1,2,3 on consecutive cycles -> y=1,0,1,0 one cycle later each, out_valid=1 each cycle. With in_valid=0 -> out_valid=0 and y holds.
2. Load AND table: send bits 1,0,0,0 (MSB first, table=4'b1000) with cfg_valid held high -> cfg_ready=1 for 4 cycles, then 0 for the COMMIT cycle; cfg_done pulses exactly once. sel=3 -> y=1; sel=0..2 -> y=0.
3. Eval during load and commit: stream sel=1 every cycle while loading 4'b0010 over the default 4'b0101 -> y=0 up to and including the COMMIT-edge result, then y=1 from the next edge.
4. Gapped cfg_valid: toggle cfg_valid 1,0,0,1,1,0,1 -> exactly 4 transfers accepted; table matches the 4 valid bits; no extra bit consumed.
5. Abort mid-load: load 4'b1111; after 2 bits assert cfg_abort together with cfg_valid -> state IDLE, no cfg_done, table still 4'b0101. A following full load of 4'b0110 (XOR) -> sel=1,2 give y=1.
6. Async reset mid-load: assert rst between clock edges after 3 bits -> outputs go low immediately. After release, table = RESET_TABLE and the next load starts at bit index TBL-1.
